// File: rtl/naseq_pkg.sv
// Shared types for the nucleic-acid sequencer: state encoding, valve-vector
// bit positions, the six-step peristaltic pump phase table and the per-state valve map.
package naseq_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_LYSE    = 4'd2,
    S_BIND    = 4'd3,
    S_TRAP    = 4'd4,
    S_WASH    = 4'd5,
    S_ELUTE   = 4'd6,
    S_COLLECT = 4'd7,
    S_DONE    = 4'd8
  } state_e;

  localparam int NUM_VALVES   = 11;
  localparam int V_LYSIS      = 0;
  localparam int V_WASH       = 1;
  localparam int V_ELUTE      = 2;
  localparam int V_HORIZ      = 3;
  localparam int V_VERTICAL   = 4;
  localparam int V_DEAD_END   = 5;
  localparam int V_LOOP_EXIT  = 6;
  localparam int V_BEAD_VTL   = 7;
  localparam int V_BEAD_TRAP  = 8;
  localparam int V_COLLECTION = 9;
  localparam int V_WASTE      = 10;

  localparam int NUM_PHASES = 6;

  // Bit order of the returned pattern is {pump1, pump2, pump3}.
  function automatic logic [2:0] pump_pattern(input logic [2:0] ph);
    case (ph)
      3'd0:    return 3'b100;
      3'd1:    return 3'b110;
      3'd2:    return 3'b010;
      3'd3:    return 3'b011;
      3'd4:    return 3'b001;
      3'd5:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic is_pumped(input state_e s);
    return (s == S_LYSE) || (s == S_BIND) || (s == S_ELUTE);
  endfunction

  function automatic logic [NUM_VALVES-1:0] valve_map(input state_e s);
    logic [NUM_VALVES-1:0] v;
    v = '0;
    case (s)
      S_LOAD:    begin v[V_HORIZ] = 1'b1; v[V_DEAD_END] = 1'b1; end
      S_LYSE:    begin v[V_LYSIS] = 1'b1; v[V_VERTICAL] = 1'b1; end
      S_BIND:    v[V_BEAD_VTL] = 1'b1;
      S_TRAP:    begin v[V_BEAD_TRAP] = 1'b1; v[V_LOOP_EXIT] = 1'b1; v[V_WASTE] = 1'b1; end
      S_WASH:    begin
        v[V_WASH] = 1'b1; v[V_VERTICAL] = 1'b1; v[V_BEAD_TRAP] = 1'b1;
        v[V_LOOP_EXIT] = 1'b1; v[V_WASTE] = 1'b1;
      end
      S_ELUTE:   begin
        v[V_ELUTE] = 1'b1; v[V_VERTICAL] = 1'b1; v[V_BEAD_TRAP] = 1'b1; v[V_LOOP_EXIT] = 1'b1;
      end
      S_COLLECT: begin v[V_BEAD_TRAP] = 1'b1; v[V_LOOP_EXIT] = 1'b1; v[V_COLLECTION] = 1'b1; end
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/nucleic_acid_sequencer_if.sv
// Host <-> sequencer signal bundle. The pause input exists only when
// NASEQ_PAUSE_EN is defined.
interface nucleic_acid_sequencer_if #(parameter int TW = 16) ();
  logic            start;
  logic            abort;
  logic [7*TW-1:0] dur;
`ifdef NASEQ_PAUSE_EN
  logic            pause;
`endif
  logic            busy;
  logic            done;
  logic            lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, dead_end_ctl;
  logic            loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl;
  logic            pump1, pump2, pump3;
  logic [3:0]      state_o;

  modport master (
`ifdef NASEQ_PAUSE_EN
    output pause,
`endif
    output start, abort, dur,
    input  busy, done, lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, dead_end_ctl,
    input  loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl,
    input  pump1, pump2, pump3, state_o
  );

  modport slave (
`ifdef NASEQ_PAUSE_EN
    input  pause,
`endif
    input  start, abort, dur,
    output busy, done, lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, dead_end_ctl,
    output loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl,
    output pump1, pump2, pump3, state_o
  );
endinterface

// File: rtl/naseq_pump_phase.sv
// Peristaltic pump phase generator: steps the six-phase pattern every PUMP_DIV
// enabled cycles; restart clears phase and divider, disable holds them and closes pumps.
module naseq_pump_phase
  import naseq_pkg::*;
#(
  parameter int PUMP_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       restart_i,
  output logic [2:0] pump_o
);
  localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

  logic [DW-1:0] div_q;
  logic [2:0]    phase_q;
  logic [2:0]    pump_q;

  // Output reflects the phase of the current cycle even on a restart edge,
  // so the last cycle of one pumped state is not cut short by the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      phase_q <= '0;
      pump_q  <= '0;
    end else begin
      pump_q <= enable_i ? pump_pattern(phase_q) : 3'b000;
      if (restart_i) begin
        div_q   <= '0;
        phase_q <= '0;
      end else if (enable_i) begin
        if (div_q == DW'(PUMP_DIV - 1)) begin
          div_q   <= '0;
          phase_q <= (phase_q == 3'(NUM_PHASES - 1)) ? 3'd0 : phase_q + 3'd1;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
    end
  end

  assign pump_o = pump_q;
endmodule

// File: rtl/nucleic_acid_sequencer.sv
// Sample-prep valve/pump sequencer: IDLE -> LOAD..COLLECT (WASH repeated) -> DONE.
// Durations in dur are packed LOAD in the low slice up to COLLECT; NASEQ_PAUSE_EN adds pause.
module nucleic_acid_sequencer
  import naseq_pkg::*;
#(
  parameter int TW        = 16,
  parameter int PUMP_DIV  = 8,
  parameter int WASH_REPS = 3
) (
  input logic                    clk,
  input logic                    rst,
  nucleic_acid_sequencer_if.slave bus
);
  localparam int WW = (WASH_REPS > 1) ? $clog2(WASH_REPS) : 1;

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [WW-1:0]           wash_q, wash_d;
  logic [7*TW-1:0]         dur_q, dur_d;
  logic [NUM_VALVES-1:0]   valve_q;
  logic                    pause, restart, pump_en;
  logic [2:0]              pump;

`ifdef NASEQ_PAUSE_EN
  assign pause = bus.pause;
`else
  assign pause = 1'b0;
`endif

  // Down-counter load value: a duration of 0 still yields one cycle.
  function automatic logic [TW-1:0] load_val(input logic [TW-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  function automatic logic [TW-1:0] slot(input logic [7*TW-1:0] dv, input state_e s);
    int idx;
    idx = int'(s) - 1;
    if (idx < 0 || idx > 6) return '0;
    return dv[idx*TW +: TW];
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    wash_d  = wash_q;
    dur_d   = dur_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      timer_d = '0;
      wash_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          state_d = S_LOAD;
          dur_d   = bus.dur;
          timer_d = load_val(bus.dur[TW-1:0]);
          wash_d  = '0;
        end
        S_LOAD, S_LYSE, S_BIND, S_TRAP, S_WASH, S_ELUTE, S_COLLECT: if (!pause) begin
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else if (state_q == S_WASH && int'(wash_q) != WASH_REPS - 1) begin
            wash_d  = wash_q + 1'b1;
            timer_d = load_val(slot(dur_q, S_WASH));
          end else begin
            state_d = state_e'(state_q + 4'd1);
            wash_d  = '0;
            timer_d = load_val(slot(dur_q, state_e'(state_q + 4'd1)));
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign restart = (state_d != state_q);
  assign pump_en = is_pumped(state_q) && !pause && !bus.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      wash_q  <= '0;
      dur_q   <= '0;
      valve_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wash_q  <= wash_d;
      dur_q   <= dur_d;
      valve_q <= bus.abort ? '0 : valve_map(state_q);
    end
  end

  naseq_pump_phase #(.PUMP_DIV(PUMP_DIV)) u_pump (
    .clk       (clk),
    .rst       (rst),
    .enable_i  (pump_en),
    .restart_i (restart),
    .pump_o    (pump)
  );

  assign bus.busy           = (state_q >= S_LOAD) && (state_q <= S_COLLECT);
  assign bus.done           = (state_q == S_DONE);
  assign bus.state_o        = state_q;
  assign bus.lysis_ctl      = valve_q[V_LYSIS];
  assign bus.wash_ctl       = valve_q[V_WASH];
  assign bus.elute_ctl      = valve_q[V_ELUTE];
  assign bus.horiz_ctl      = valve_q[V_HORIZ];
  assign bus.vertical_ctl   = valve_q[V_VERTICAL];
  assign bus.dead_end_ctl   = valve_q[V_DEAD_END];
  assign bus.loop_exit_ctl  = valve_q[V_LOOP_EXIT];
  assign bus.bead_vtl_ctl   = valve_q[V_BEAD_VTL];
  assign bus.bead_trap_ctl  = valve_q[V_BEAD_TRAP];
  assign bus.collection_ctl = valve_q[V_COLLECTION];
  assign bus.waste_ctl      = valve_q[V_WASTE];
  assign bus.pump1          = pump[2];
  assign bus.pump2          = pump[1];
  assign bus.pump3          = pump[0];
endmodule

// File: tb/tb_nucleic_acid_sequencer.sv
// Self-checking bench for nucleic_acid_sequencer; the pause scenario is built
// only when NASEQ_PAUSE_EN is defined.
module tb_nucleic_acid_sequencer;
  localparam int TW        = 8;
  localparam int PUMP_DIV  = 2;
  localparam int WASH_REPS = 3;

  logic clk = 1'b0;
  logic rst;

  nucleic_acid_sequencer_if #(.TW(TW)) bus ();

  nucleic_acid_sequencer #(.TW(TW), .PUMP_DIV(PUMP_DIV), .WASH_REPS(WASH_REPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt, done_cnt;

  typedef struct {
    int st;
    int k;
    bit paused;
    bit aborted;
  } rec_t;
  rec_t q[$];

  // Order: lysis wash elute horiz vertical dead_end loop_exit bead_vtl bead_trap collection waste
  function automatic logic [10:0] exp_valves(input int st);
    case (st)
      1:       return 11'b00010100000;
      2:       return 11'b10001000000;
      3:       return 11'b00000001000;
      4:       return 11'b00000010101;
      5:       return 11'b01001010101;
      6:       return 11'b00101010100;
      7:       return 11'b00000010110;
      default: return 11'b00000000000;
    endcase
  endfunction

  function automatic logic [2:0] exp_pump(input int k);
    case ((k / PUMP_DIV) % 6)
      0:       return 3'b100;
      1:       return 3'b110;
      2:       return 3'b010;
      3:       return 3'b011;
      4:       return 3'b001;
      default: return 3'b101;
    endcase
  endfunction

  function automatic logic [10:0] valves_now();
    return {bus.lysis_ctl, bus.wash_ctl, bus.elute_ctl, bus.horiz_ctl, bus.vertical_ctl,
            bus.dead_end_ctl, bus.loop_exit_ctl, bus.bead_vtl_ctl, bus.bead_trap_ctl,
            bus.collection_ctl, bus.waste_ctl};
  endfunction

  function automatic logic [2:0] pumps_now();
    return {bus.pump1, bus.pump2, bus.pump3};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"},  32'(bus.state_o),  32'd0);
    check({tag, "_busy"},   32'(bus.busy),     32'd0);
    check({tag, "_done"},   32'(bus.done),     32'd0);
    check({tag, "_valves"}, 32'(valves_now()), 32'd0);
    check({tag, "_pumps"},  32'(pumps_now()),  32'd0);
  endtask

  // Expected behaviour is an explicit per-cycle schedule built from the durations.
  task automatic run_check(input logic [7*TW-1:0] d, input int abort_at, input int pause_at,
                           input bit hold);
    rec_t        r;
    int          n, reps;
    logic [10:0] ev;
    logic [2:0]  ep;
    bit          pumped;
    q.delete();
    r.paused  = 1'b0;
    r.aborted = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      n = int'(d[(s-1)*TW +: TW]);
      if (n == 0) n = 1;
      reps = (s == 5) ? WASH_REPS : 1;
      for (int j = 0; j < n * reps; j++) begin
        r.st = s;
        r.k  = j;
        q.push_back(r);
      end
    end
    r.st = 8; r.k = 0; q.push_back(r);
    r.st = 0; q.push_back(r);
    if (pause_at >= 0 && pause_at < q.size()) begin
      r = q[pause_at];
      r.paused = 1'b1;
      repeat (5) q.insert(pause_at, r);
    end
    if (abort_at >= 0 && abort_at < q.size()) begin
      while (q.size() > abort_at + 1) void'(q.pop_back());
      q[abort_at].aborted = 1'b1;
      r.st = 0; r.k = 0; r.paused = 1'b0; r.aborted = 1'b0;
      q.push_back(r);
    end

    @(negedge clk);
    bus.start = 1'b1;
    bus.dur   = d;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < q.size(); i++) begin
      ev = '0;
      ep = '0;
      if (i > 0 && !q[i-1].aborted) begin
        ev = exp_valves(q[i-1].st);
        pumped = (q[i-1].st == 2) || (q[i-1].st == 3) || (q[i-1].st == 6);
        if (pumped && !q[i-1].paused) ep = exp_pump(q[i-1].k);
      end
      check("state",  32'(bus.state_o), 32'(q[i].st));
      check("busy",   32'(bus.busy),    32'((q[i].st >= 1) && (q[i].st <= 7)));
      check("done",   32'(bus.done),    32'(q[i].st == 8));
      check("valves", 32'(valves_now()), 32'(ev));
      check("pumps",  32'(pumps_now()),  32'(ep));
      check("exclusive",
            32'(((int'(bus.lysis_ctl) + int'(bus.wash_ctl) + int'(bus.elute_ctl)) <= 1) &&
                !(bus.collection_ctl && bus.waste_ctl)), 32'd1);
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
`ifdef NASEQ_PAUSE_EN
      bus.pause = q[i].paused;
`endif
      bus.abort = q[i].aborted;
      @(posedge clk); #1;
    end
    bus.abort = 1'b0;
`ifdef NASEQ_PAUSE_EN
    bus.pause = 1'b0;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7*TW-1:0] d4, dl, dt, dr, de;
    int              ab;
    bit              found;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.dur   = '0;
`ifdef NASEQ_PAUSE_EN
    bus.pause = 1'b0;
`endif
    rst = 1'b1;
    #2;
    check_idle("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check_idle("post_reset");

    d4 = {7{8'd4}};
    run_check(d4, -1, -1, 1'b0);
    check("busy_cycles", 32'(busy_cnt), 32'd36);
    check("done_pulses", 32'(done_cnt), 32'd1);

    dl = {7{8'd1}};
    dl[TW +: TW] = 8'd12;
    run_check(dl, -1, -1, 1'b0);

    run_check(d4, 21, -1, 1'b0);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check_idle("after_abort");

    dt = d4;
    dt[3*TW +: TW] = 8'd0;
    run_check(dt, -1, -1, 1'b1);
    check("restart_load", 32'(bus.state_o), 32'd1);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check_idle("abort_after_restart");

`ifdef NASEQ_PAUSE_EN
    run_check(d4, -1, 10, 1'b0);
    check("pause_busy_cycles", 32'(busy_cnt), 32'd41);
`endif

    for (int t = 0; t < 8; t++) begin
      for (int s = 0; s < 7; s++) dr[s*TW +: TW] = 8'($urandom_range(0, 5));
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1;
      run_check(dr, ab, -1, 1'b0);
    end

    de = {7{8'd2}};
    de[5*TW +: TW] = 8'd6;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dur   = de;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (bus.state_o == 4'd6) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("reach_elute", 32'(found), 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("elute_pump", 32'(pumps_now()), 32'b100);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    @(negedge clk) rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check_idle("no_resume");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nucleic_acid_sequencer.md
NUCLEIC_ACID_SEQUENCER -- requirements
Module: nucleic_acid_sequencer

Interface
REQ-001 SHALL have parameter TW, default 16, width of the step timer and duration inputs.
REQ-002 SHALL have parameter PUMP_DIV, default 8, clock cycles per pump phase step (>=1).
REQ-003 SHALL have parameter WASH_REPS, default 3, number of WASH passes (>=1).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports start / abort  input  1 each  run request and immediate stop.
REQ-007 SHALL have port dur  input  7*TW  step durations, packed in state order LOAD..COLLECT, sampled at start.
REQ-008 SHALL have ports busy / done  output  1 each  run in progress and one-cycle completion pulse.
REQ-009 SHALL have ports lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, dead_end_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl  output  1 each  valve drives, 1 = open.
REQ-010 SHALL have ports pump1, pump2, pump3  output  1 each  peristaltic pump valve drives, 1 = open.
REQ-011 SHALL have port state_o  output  4  current state encoding, for debug.

Function
REQ-012 SHALL implement states IDLE, LOAD, LYSE, BIND, TRAP, WASH, ELUTE, COLLECT, DONE, in that order.
REQ-013 SHALL leave IDLE for LOAD on start=1 and abort=0; start outside IDLE is ignored.
REQ-014 SHALL latch dur on the start cycle; each timed state lasts exactly its duration in cycles; duration 0 is treated as 1.
REQ-015 SHALL repeat WASH WASH_REPS times, timer reloaded each pass, before entering ELUTE.
REQ-016 SHALL hold DONE exactly one cycle with done=1, then return to IDLE; busy=1 in LOAD..COLLECT only.
REQ-017 SHALL open per state: LOAD horiz+dead_end; LYSE lysis+vertical; BIND bead_vtl; TRAP bead_trap+loop_exit+waste; WASH wash+vertical+bead_trap+loop_exit+waste; ELUTE elute+vertical+bead_trap+loop_exit; COLLECT bead_trap+loop_exit+collection; all others closed.
REQ-018 SHALL register all valve outputs, driven one cycle after the state register (state_o leads valves by 1 cycle).
REQ-019 SHALL run pumps only in LYSE, BIND, ELUTE, advancing one phase every PUMP_DIV cycles through 100,110,010,011,001,101 (pump1,pump2,pump3), wrapping to 100.
REQ-020 SHALL restart pump phase at 100 with divider cleared on each entry to a pumped state; pumps = 000 otherwise.
REQ-021 SHALL never open two of lysis/wash/elute, nor collection and waste, in the same cycle.
REQ-022 SHALL on abort=1 in any state go to IDLE next cycle, close all valves, and not assert done; abort has priority over start and timer expiry.

Reset
REQ-023 SHALL on rst=1 force IDLE, timer, wash count, pump divider and phase to 0, all valves and pumps 0, busy=0, done=0, state_o=IDLE, independent of clk.
REQ-024 SHALL treat rst mid-run identically to REQ-023; no run resumes after release.

Configuration
REQ-025 SHALL with NASEQ_PAUSE_EN defined add input pause (1 bit): while pause=1 in a busy state, timer, wash count and pump phase/divider freeze, pumps drive 000, other valves hold; abort still honoured.
REQ-026 SHALL without NASEQ_PAUSE_EN have no pause port and behave as if pause=0.

Structure
REQ-027 SHALL place the state enum, valve-vector bit indices and pump phase table in package naseq_pkg.
REQ-028 SHALL implement pump phase generation as sub-module naseq_pump_phase (enable, restart, 3-bit output).

Verification
REQ-029 Run with all durations 4, PUMP_DIV=2, WASH_REPS=3 -> busy for 4*(6+3)=36 cycles, done pulses once, states visited in order.
REQ-030 LYSE of 12 cycles, PUMP_DIV=2 -> pump sequence 100,100,110,110,010,010,011,011,001,001,101,101.
REQ-031 abort in WASH pass 2 -> IDLE next cycle, all outputs 0, no done pulse.
REQ-032 rst asserted asynchronously mid-ELUTE -> outputs 0 before next clk edge.
REQ-033 Duration 0 for TRAP, start held high through DONE -> TRAP lasts 1 cycle; no re-start until IDLE with start seen again.
REQ-034 With NASEQ_PAUSE_EN, pause 5 cycles in BIND -> BIND extended by 5 cycles, pumps 000 while paused, phase resumes unchanged.
